// File: rtl/hex_pkg.sv
// Shared constants for the multiplexed hex display controller: register map,
// CTRL bit positions, segment glyphs and the internal bus request bundle.
package hex_pkg;

  localparam logic [23:0] OFS_DIGIT0  = 24'h00;
  localparam logic [23:0] OFS_BITMASK = 24'h40;
  localparam logic [23:0] OFS_BLINK   = 24'h44;
  localparam logic [23:0] OFS_CTRL    = 24'h48;
  localparam logic [23:0] OFS_RESET   = 24'h4C;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;

  // Active-low segments, bit 6 = g ... bit 0 = a; entry 0 is the rightmost word.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [23:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// 4-bit value to active-low 7-segment glyph, purely combinational.
module hex_seg_decoder
  import hex_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPHS[val_i];

endmodule

// File: rtl/hex_mux_sb_ctrl.sv
// Bus-mapped controller for a time-multiplexed hex display with per-digit
// enable and blink; one digit is lit per scan slot.
module hex_mux_sb_ctrl
  import hex_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_enable_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  output logic [6:0]        hex_led_o,
  output logic              hex_dp_o,
  output logic [DIGITS-1:0] hex_sel_o
);

  localparam int SCAN_W  = cnt_w(SCAN_DIV);
  localparam int BLINK_W = cnt_w(BLINK_DIV);
  localparam int IDX_W   = cnt_w(DIGITS);

  bus_req_t bus;
  assign bus.wr    = req_i & write_enable_i;
  assign bus.rd    = req_i & ~write_enable_i;
  assign bus.addr  = addr_i[23:0];
  assign bus.wdata = write_data_i;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:24], write_data_i};

  logic [DIGITS-1:0][4:0] digit_q;
  logic [DIGITS-1:0]      mask_q, blink_q;
  logic [1:0]             ctrl_q;
  logic [31:0]            read_data_q, read_data_d;
  logic [SCAN_W-1:0]      scan_q;
  logic [BLINK_W-1:0]     blink_cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   phase_q;
  logic [DIGITS-1:0]      sel_q, sel_d;
  logic [6:0]             led_q, led_d;
  logic                   dp_q, dp_d;

  // Address decode; DIGITn slots occupy 0x00..0x3C but only n < DIGITS exist.
  logic [3:0] dig_n;
  logic       dig_hit, soft_rst, rst_all;
  assign dig_n    = bus.addr[5:2];
  assign dig_hit  = (bus.addr[23:6] == '0) && (bus.addr[1:0] == 2'b00) &&
                    (32'(dig_n) < 32'(DIGITS));
  assign soft_rst = bus.wr && (bus.addr == OFS_RESET);
  assign rst_all  = rst_i | soft_rst;

  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      digit_q <= '0;
      mask_q  <= '1;
      blink_q <= '0;
      ctrl_q  <= 2'b01;
    end else if (bus.wr) begin
      if (dig_hit) begin
        for (int k = 0; k < DIGITS; k++)
          if (dig_n == 4'(k)) digit_q[k] <= bus.wdata[4:0];
      end
      if (bus.addr == OFS_BITMASK) mask_q  <= bus.wdata[DIGITS-1:0];
      if (bus.addr == OFS_BLINK)   blink_q <= bus.wdata[DIGITS-1:0];
      if (bus.addr == OFS_CTRL)    ctrl_q  <= bus.wdata[1:0];
    end
  end

  always_comb begin
    read_data_d = '0;
    if (dig_hit) begin
      for (int k = 0; k < DIGITS; k++)
        if (dig_n == 4'(k)) read_data_d = 32'(digit_q[k]);
    end else begin
      case (bus.addr)
        OFS_BITMASK: read_data_d = 32'(mask_q);
        OFS_BLINK:   read_data_d = 32'(blink_q);
        OFS_CTRL:    read_data_d = 32'(ctrl_q);
        default:     read_data_d = '0;
      endcase
    end
  end

  // Soft reset deliberately leaves the last read result in place.
  always_ff @(posedge clk_i) begin
    if (rst_i)       read_data_q <= '0;
    else if (bus.rd) read_data_q <= read_data_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      scan_q      <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  logic [4:0]        cur_dig;
  logic              cur_mask, cur_blink, vis;
  logic [DIGITS-1:0] sel_onehot;
  logic [6:0]        seg;

  always_comb begin
    cur_dig    = '0;
    cur_mask   = 1'b0;
    cur_blink  = 1'b0;
    sel_onehot = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_dig       = digit_q[k];
        cur_mask      = mask_q[k];
        cur_blink     = blink_q[k];
        sel_onehot[k] = 1'b0;
      end
    end
  end

  // phase_q = 0 is the dark half of the blink period.
  assign vis = ctrl_q[CTRL_EN_BIT] & cur_mask &
               ~(ctrl_q[CTRL_BLINK_BIT] & cur_blink & ~phase_q);

  hex_seg_decoder u_dec (
    .val_i (cur_dig[3:0]),
    .seg_o (seg)
  );

  always_comb begin
    sel_d = vis ? sel_onehot : '1;
    led_d = vis ? seg : 7'h7F;
    dp_d  = vis ? ~cur_dig[4] : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      sel_q <= '1;
      led_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      sel_q <= sel_d;
      led_q <= led_d;
      dp_q  <= dp_d;
    end
  end

  assign read_data_o = read_data_q;
  assign hex_sel_o   = sel_q;
  assign hex_led_o   = led_q;
  assign hex_dp_o    = dp_q;

endmodule

// File: tb/tb_hex_mux_sb_ctrl.sv
// Directed plus randomized bench for hex_mux_sb_ctrl against a cycle-count
// based reference model of the display scan and register file.
module tb_hex_mux_sb_ctrl;

  localparam int D  = 8;
  localparam int SD = 4;
  localparam int BD = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [31:0] addr, wd, rd;
  logic [6:0]  led;
  logic        dp;
  logic [D-1:0] sel;

  logic        b_rst, b_req, b_we;
  logic [31:0] b_addr, b_wd, b_rd;
  logic [6:0]  b_led;
  logic        b_dp;
  logic [3:0]  b_sel;

  hex_mux_sb_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_enable_i(we),
    .addr_i(addr), .write_data_i(wd), .read_data_o(rd),
    .hex_led_o(led), .hex_dp_o(dp), .hex_sel_o(sel)
  );

  hex_mux_sb_ctrl #(.DIGITS(4), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut4 (
    .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .write_enable_i(b_we),
    .addr_i(b_addr), .write_data_i(b_wd), .read_data_o(b_rd),
    .hex_led_o(b_led), .hex_dp_o(b_dp), .hex_sel_o(b_sel)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: register contents plus edges elapsed since last reset.
  int          mdig [D];
  int          mmask, mblink, mctrl, e;
  logic [31:0] mrd;

  logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] AL [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                          32'h1C, 32'h20, 32'h40, 32'h44, 32'h48, 32'h100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) mdig[i] = 0;
    mmask  = 8'hFF;
    mblink = 0;
    mctrl  = 1;
    e      = 0;
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [23:0] a24;
    a24 = a[23:0];
    if (a24 < 24'h20 && a24[1:0] == 2'b00) return 32'(mdig[a24[4:2]]);
    case (a24)
      24'h40:  return 32'(mmask);
      24'h44:  return 32'(mblink);
      24'h48:  return 32'(mctrl);
      default: return 32'h0;
    endcase
  endfunction

  // One clock: drive, predict, advance model, then compare every output.
  task automatic tick(input bit r, input bit rq, input bit w,
                      input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  xs;
    logic [6:0]  xl;
    logic        xd;
    logic [23:0] a24;
    int          idx;
    bit          ph, vis;
    rst = r; req = rq; we = w; addr = a; wd = d;
    a24 = a[23:0];
    if (r || (rq && w && a24 == 24'h4C)) begin
      xs = 8'hFF; xl = 7'h7F; xd = 1'b1;
      model_reset();
      if (r) mrd = 32'h0;
    end else begin
      idx = (e / SD) % D;
      ph  = ((e / BD) % 2) == 0;
      vis = mctrl[0] && mmask[idx] && !(mctrl[1] && mblink[idx] && !ph);
      xs  = vis ? ~(8'd1 << idx) : 8'hFF;
      xl  = vis ? GLY[mdig[idx] & 15] : 7'h7F;
      xd  = vis ? ~mdig[idx][4] : 1'b1;
      if (rq && !w) mrd = mread(a);
      if (rq && w) begin
        if (a24 < 24'h20 && a24[1:0] == 2'b00) mdig[a24[4:2]] = int'(d[4:0]);
        else if (a24 == 24'h40) mmask  = int'(d[7:0]);
        else if (a24 == 24'h44) mblink = int'(d[7:0]);
        else if (a24 == 24'h48) mctrl  = int'(d[1:0]);
      end
      e++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("sel", 32'(sel), 32'(xs));
    chk("led", 32'(led), 32'(xl));
    chk("dp", 32'(dp), 32'(xd));
    chk("rdata", rd, mrd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic btick(input bit r, input bit rq, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    b_rst = r; b_req = rq; b_we = w; b_addr = a; b_wd = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wd = '0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wd = '0;
    mrd = 32'h0;
    model_reset();
    @(negedge clk);
    tick(1, 0, 0, 32'h0, 32'h0);
    tick(1, 0, 0, 32'h0, 32'h0);

    // Basic write/readback and unmapped read.
    tick(0, 1, 1, 32'h08, 32'h5);
    tick(0, 1, 0, 32'h08, 32'h0);
    chk("rd_digit2", rd, 32'h5);
    tick(0, 1, 0, 32'h100, 32'h0);
    chk("rd_unmapped", rd, 32'h0);

    // Scan order right after reset.
    tick(1, 0, 0, 32'h0, 32'h0);
    for (int i = 1; i <= 33; i++) begin
      tick(0, 0, 0, 32'h0, 32'h0);
      if (i == 1)  chk("scan_slot0", 32'(sel), 32'hFE);
      if (i == 1)  chk("scan_glyph0", 32'(led), 32'h40);
      if (i == 5)  chk("scan_slot1", 32'(sel), 32'hFD);
      if (i == 29) chk("scan_slot7", 32'(sel), 32'h7F);
      if (i == 33) chk("scan_wrap", 32'(sel), 32'hFE);
    end

    // Only digit 0 enabled.
    tick(0, 1, 1, 32'h40, 32'h01);
    idle(40);

    // Blink digit 0 across several half-periods.
    tick(0, 1, 1, 32'h40, 32'hFF);
    tick(0, 1, 1, 32'h44, 32'h01);
    tick(0, 1, 1, 32'h48, 32'h3);
    idle(300);

    // Digit 0 = 3 with decimal point.
    tick(1, 0, 0, 32'h0, 32'h0);
    tick(0, 1, 1, 32'h00, 32'h13);
    tick(0, 0, 0, 32'h0, 32'h0);
    chk("glyph3", 32'(led), 32'h30);
    chk("dp_on", 32'(dp), 32'h0);

    // Soft reset mid-scan while a read result is held.
    tick(0, 1, 1, 32'h08, 32'h9);
    tick(0, 1, 0, 32'h08, 32'h0);
    guard = 0;
    while (((e / SD) % D) != 5 && guard < 100) begin
      tick(0, 0, 0, 32'h0, 32'h0);
      guard++;
    end
    chk("slot5_reached", 32'((e / SD) % D), 32'h5);
    tick(0, 1, 1, 32'h4C, $urandom);
    chk("srst_sel", 32'(sel), 32'hFF);
    chk("srst_rd_hold", rd, 32'h9);
    tick(0, 1, 0, 32'h08, 32'h0);
    chk("srst_restart", 32'(sel), 32'hFE);
    chk("srst_digit2", rd, 32'h0);
    tick(0, 1, 0, 32'h40, 32'h0);
    chk("srst_mask", rd, 32'hFF);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 199));
      a = AL[$urandom_range(0, 12)] | (($urandom_range(0, 1) == 1) ? 32'hAB000000 : 32'h0);
      if (r < 1)        tick(1, 0, 0, 32'h0, 32'h0);
      else if (r < 4)   tick(0, 1, 1, 32'h4C, $urandom);
      else if (r < 50)  tick(0, 1, 1, a, $urandom);
      else if (r < 100) tick(0, 1, 0, a, $urandom);
      else              tick(0, 0, 0, a, $urandom);
    end

    // Four-digit instance: DIGIT7 does not exist.
    btick(1, 0, 0, 32'h0, 32'h0);
    btick(0, 1, 1, 32'h1C, 32'h1F);
    btick(0, 1, 1, 32'h0C, 32'h17);
    btick(0, 1, 0, 32'h0C, 32'h0);
    chk("d4_digit3", b_rd, 32'h17);
    btick(0, 1, 0, 32'h1C, 32'h0);
    chk("d4_digit7", b_rd, 32'h0);
    btick(0, 1, 0, 32'h40, 32'h0);
    chk("d4_mask", b_rd, 32'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_mux_sb_ctrl.md
HEX_MUX_SB_CTRL -- requirements
Module: hex_mux_sb_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning number of digits, legal 1..16.
REQ-002 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per digit scan slot, legal >=2.
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, meaning clock cycles per blink half-period, legal >=2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_i, input, 1 bit: bus request.
REQ-007 SHALL have port write_enable_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port addr_i, input, 32 bits: byte address; only bits [23:0] are decoded.
REQ-009 SHALL have port write_data_i, input, 32 bits: write data.
REQ-010 SHALL have port read_data_o, output, 32 bits: registered read data.
REQ-011 SHALL have port hex_led_o, output, 7 bits: segments a..g, active-low.
REQ-012 SHALL have port hex_dp_o, output, 1 bit: decimal point, active-low.
REQ-013 SHALL have port hex_sel_o, output, DIGITS bits: digit anodes, active-low one-hot or all-ones.

Function
REQ-014 SHALL implement the register map: DIGITn at 0x00+4*n (bits [4:0] = {dp, value[3:0]}); BITMASK at 0x40 (bits [DIGITS-1:0], 1 = digit enabled); BLINK at 0x44 (bits [DIGITS-1:0], 1 = digit blinks); CTRL at 0x48 (bit0 = display enable, bit1 = blink enable); RESET at 0x4C (write-only).
REQ-015 SHALL perform a write when req_i & write_enable_i, updating the addressed register at the next clock edge.
REQ-016 SHALL ignore writes to unmapped addresses and to DIGITn with n >= DIGITS.
REQ-017 SHALL, on a read (req_i & ~write_enable_i), present the zero-extended register value on read_data_o one cycle later.
REQ-018 SHALL return 0 for reads of unmapped addresses, DIGITn with n >= DIGITS, and RESET; read_data_o SHALL hold its value when there is no read.
REQ-019 SHALL treat any write to RESET (data ignored) as a soft reset with the same effect as rst_i on all registers, counters and display outputs, but not on read_data_o.
REQ-020 SHALL run a scan counter 0..SCAN_DIV-1; on wrap, the digit index SHALL advance modulo DIGITS (DIGITS-1 -> 0).
REQ-021 SHALL run a blink counter 0..BLINK_DIV-1; on wrap, blink_phase SHALL toggle; blink_phase SHALL reset to 1 (visible).
REQ-022 SHALL define digit k as visible when CTRL.en & BITMASK[k] & ~(CTRL.blink & BLINK[k] & ~blink_phase).
REQ-023 SHALL register the display outputs, with 1-cycle latency from the current digit index and register state.
REQ-024 SHALL, when the current digit k is visible, drive hex_sel_o[k]=0 (all others 1), hex_led_o = decode(value_k) and hex_dp_o = ~dp_k.
REQ-025 SHALL, when the current digit is not visible, drive hex_sel_o all-ones and hex_led_o, hex_dp_o all-ones.
REQ-026 SHALL use the decode map 0-F -> standard hex glyphs (e.g. 0 -> 7'b1000000 with bit 6 = g, 8 -> 7'b0000000, F -> 7'b0001110).
REQ-027 SHALL NOT let register writes reset or stall the scan or blink counters.

Reset
REQ-028 SHALL, on rst_i, set DIGITn = 0, BITMASK = all-ones, BLINK = 0, CTRL = 2'b01, counters = 0, digit index = 0, blink_phase = 1, hex_sel_o/hex_led_o/hex_dp_o = all-ones, read_data_o = 0.
REQ-029 SHALL give rst_i or a soft reset priority over a simultaneous write; a reset asserted mid-scan restarts the scan at digit 0.

Structure
REQ-030 SHALL take its register offsets, CTRL bit positions and the 16-entry segment glyph constant from a shared package, hex_pkg.
REQ-031 SHALL implement decode as one combinational sub-module, hex_seg_decoder (4-bit in, 7-bit active-low out).
REQ-032 SHALL size counter widths with $clog2 of SCAN_DIV, BLINK_DIV and DIGITS (minimum 1 bit).

Verification (DIGITS=8, SCAN_DIV=4, BLINK_DIV=64)
REQ-033 SHALL check: write 0x5 to 0x08, then read 0x08 -> read_data_o = 0x5 on the next cycle; read 0x100 -> 0.
REQ-034 SHALL check: after reset, the digit index advances every 4 cycles; hex_sel_o cycles FE, FD, ... 7F, FE; hex_led_o = 7'b1000000.
REQ-035 SHALL check: write BITMASK = 0x01 -> hex_sel_o = FE during slot 0 and FF in slots 1..7.
REQ-036 SHALL check: BLINK = 0x01 and CTRL = 0x3 -> digit 0 is visible for 64 cycles, blank for 64, repeating; other digits are unaffected.
REQ-037 SHALL check: write 0x13 to 0x00 -> in slot 0, hex_led_o = glyph 3 and hex_dp_o = 0.
REQ-038 SHALL check: write RESET during slot 5 while DIGIT2 = 0x9 -> next cycle all registers are at reset values, hex_sel_o = FF, the scan restarts at digit 0, and read_data_o is unchanged; a write to 0x1C with DIGITS=4 is ignored and reads back as 0.
